// File: rtl/telemetry.sv
// Periodic A2D telemetry packet sender over an 8N1 UART on TX.
// Define TELEM_CHECKSUM_EN to append an inverted-sum checksum byte to each packet.
module telemetry #(
  parameter int BAUD_DIV    = 2604,
  parameter int PERIOD_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        pkt_busy
);

  // state | meaning
  // IDLE  | line high, waiting for the period tick
  // START | start bit (TX low) of the current byte
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (TX high), then next byte or back to IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

`ifdef TELEM_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  logic [PERIOD_BITS-1:0] timer;
  logic                   tick;
  logic [1:0]             state;
  logic [11:0]            baud_cnt;
  logic [2:0]             bit_cnt;
  logic [3:0]             byte_idx;
  logic [3:0]             next_idx;
  logic [7:0]             shift;
  logic [7:0]             next_byte;
  logic [11:0]            batt_sh;
  logic [11:0]            curr_sh;
  logic [11:0]            torque_sh;
  logic                   baud_done;

  assign tick      = &timer;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign next_idx  = byte_idx + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else        timer <= timer + PERIOD_BITS'(1);
  end

`ifdef TELEM_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = ~({4'h0, batt_sh[11:8]} + batt_sh[7:0] +
                  {4'h0, curr_sh[11:8]} + curr_sh[7:0] +
                  {4'h0, torque_sh[11:8]} + torque_sh[7:0]);
`endif

  // Byte 0 (0xAA) is loaded directly from IDLE, so only bytes 1..LAST_IDX come from here.
  always_comb begin
    next_byte = 8'h00;
    case (next_idx)
      4'd1:    next_byte = 8'h55;
      4'd2:    next_byte = {4'h0, batt_sh[11:8]};
      4'd3:    next_byte = batt_sh[7:0];
      4'd4:    next_byte = {4'h0, curr_sh[11:8]};
      4'd5:    next_byte = curr_sh[7:0];
      4'd6:    next_byte = {4'h0, torque_sh[11:8]};
      4'd7:    next_byte = torque_sh[7:0];
`ifdef TELEM_CHECKSUM_EN
      4'd8:    next_byte = csum;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift     <= '0;
      batt_sh   <= '0;
      curr_sh   <= '0;
      torque_sh <= '0;
      TX        <= 1'b1;
      pkt_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (tick) begin
            state     <= START;
            batt_sh   <= batt;
            curr_sh   <= curr;
            torque_sh <= torque;
            shift     <= 8'hAA;
            byte_idx  <= '0;
            TX        <= 1'b0;
            pkt_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TX       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              TX      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
        default: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx < LAST_IDX) begin
              state    <= START;
              byte_idx <= next_idx;
              shift    <= next_byte;
              TX       <= 1'b0;
            end else begin
              state    <= IDLE;
              pkt_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 12'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telemetry.sv
// Scoreboard bench for telemetry: a fast instance (4 clk/bit) and a slow one (16 clk/bit, packets overlap ticks).
module tb_telemetry;

  localparam int PERIOD = 1024;
`ifdef TELEM_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int BD0 = 4;
  localparam int BD1 = 16;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt = 12'hABC;
  logic [11:0] curr = 12'h123;
  logic [11:0] torque = 12'h7F0;
  logic        tx0, tx1, busy0, busy1;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt;
  int   free_at[2];
  logic pushed0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  telemetry #(.BAUD_DIV(BD0), .PERIOD_BITS(10)) u_fast (
    .clk(clk), .rst_n(rst_n), .batt(batt), .curr(curr), .torque(torque),
    .TX(tx0), .pkt_busy(busy0));

  telemetry #(.BAUD_DIV(BD1), .PERIOD_BITS(10)) u_slow (
    .clk(clk), .rst_n(rst_n), .batt(batt), .curr(curr), .torque(torque),
    .TX(tx1), .pkt_busy(busy1));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packet: header, then each 12-bit value as high nibble byte and low byte.
  task automatic push_packet(input int sel, input int start_edge, input int bdiv);
    logic [7:0] pk[9];
    int         sum;
    exp_t       e;
    pk[0] = 8'hAA;
    pk[1] = 8'h55;
    pk[2] = 8'(batt / 256);   pk[3] = 8'(batt % 256);
    pk[4] = 8'(curr / 256);   pk[5] = 8'(curr % 256);
    pk[6] = 8'(torque / 256); pk[7] = 8'(torque % 256);
    sum = 0;
    for (int i = 2; i < 8; i++) sum += int'(pk[i]);
    pk[8] = 8'(255 - (sum % 256));
    for (int i = 0; i < NB; i++) begin
      e.data  = pk[i];
      e.start = start_edge + i * 10 * bdiv;
      if (sel == 0) exp_q0.push_back(e);
      else          exp_q1.push_back(e);
    end
  endtask

  // A packet starts on the first edge that is a multiple of the period while the sender is free.
  task automatic model_step();
    int up;
    if (rst_n) begin
      up = edge_cnt + 1;
      if (up % PERIOD == 0) begin
        if (up >= free_at[0]) begin
          push_packet(0, up, BD0);
          free_at[0] = up + NB * 10 * BD0 + 1;
          pushed0 = 1'b1;
        end
        if (up >= free_at[1]) begin
          push_packet(1, up, BD1);
          free_at[1] = up + NB * 10 * BD1 + 1;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic uart_mon(input int sel, input int bdiv);
    logic [9:0] bits;
    logic       stable;
    logic       aborted;
    int         s;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n && get_tx(sel) == 1'b0) begin
        s = edge_cnt;
        aborted = 1'b0;
        stable = 1'b1;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < bdiv; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            if (aborted) break;
            if (c == 0) bits[b] = get_tx(sel);
            else if (get_tx(sel) !== bits[b]) stable = 1'b0;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
            check($sformatf("unexpected_frame%0d", sel), int'(bits[8:1]), -1);
          end else begin
            e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("byte%0d", sel), int'(bits[8:1]), int'(e.data));
            check($sformatf("start_edge%0d", sel), s, e.start);
            check($sformatf("framing%0d", sel),
                  int'(stable && bits[0] == 1'b0 && bits[9] == 1'b1), 1);
          end
        end
      end
    end
  endtask

  task automatic busy_mon(input int sel, input int bdiv);
    logic in_pkt;
    int   r;
    in_pkt = 1'b0;
    r = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_pkt = 1'b0;
      else if (get_busy(sel) && !in_pkt) begin
        in_pkt = 1'b1;
        r = edge_cnt;
      end else if (!get_busy(sel) && in_pkt) begin
        in_pkt = 1'b0;
        check($sformatf("busy_len%0d", sel), edge_cnt - r, NB * 10 * bdiv);
      end
    end
  endtask

  initial begin
    fork
      uart_mon(0, BD0);
      uart_mon(1, BD1);
      busy_mon(0, BD0);
      busy_mon(1, BD1);
    join_none
  end

  initial begin
    free_at[0] = 0;
    free_at[1] = 0;
    pushed0 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx0", int'(tx0), 1);
    check("rst_tx1", int'(tx1), 1);
    check("rst_busy0", int'(busy0), 0);
    check("rst_busy1", int'(busy1), 0);
    rst_n = 1'b1;

    // Directed: first packet with fixed data, batt cleared mid-packet.
    run_cycles(1100);
    batt = 12'h000;
    run_cycles(1100);

    // Random data, changed at random points including mid-packet.
    for (int i = 0; i < 14; i++) begin
      run_cycles($urandom_range(40, 400));
      batt   = 12'($urandom);
      curr   = 12'($urandom);
      torque = 12'($urandom);
    end

    // Reset during byte 3 of a fast packet.
    pushed0 = 1'b0;
    for (int i = 0; i < 1100 && !pushed0; i++) run_cycles(1);
    check("packet_seen_before_reset", int'(pushed0), 1);
    run_cycles(3 * 10 * BD0 + 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx0", int'(tx0), 1);
    check("midrst_tx1", int'(tx1), 1);
    check("midrst_busy0", int'(busy0), 0);
    exp_q0.delete();
    exp_q1.delete();
    free_at[0] = 0;
    free_at[1] = 0;
    batt   = 12'hABC;
    curr   = 12'h123;
    torque = 12'h7F0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2400);

    check("drain0", exp_q0.size(), 0);
    check("drain1", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
